// File: rtl/aqp_audio_sched.sv
// rtl/aqp_audio_sched.sv - stereo sample FIFO with rate divider feeding a PWM DAC.
// Optional low-water interrupt is built only when AQP_AUDIO_SCHED_IRQ_EN is defined.
module aqp_audio_sched #(
  parameter int FIFO_AW     = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [15:0]        rate_div,
  input  logic               wr_en,
  input  logic [31:0]        wr_data,
  input  logic               status_clr,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               underrun,
  output logic               overflow,
  output logic               irq,
  output logic               next_sample,
  output logic [15:0]        left_data,
  output logic [15:0]        right_data
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_LV = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] PRIME_LV = (FIFO_AW+1)'(PRIME_LEVEL);

  typedef enum logic [1:0] {ST_OFF, ST_PRIME, ST_RUN} state_t;

  state_t               state, state_n;
  logic [15:0]          counter;
  logic                 tick, empty;
  logic                 push, pop, drop, starve, flush;
  logic [31:0]          mem [DEPTH];
  logic [31:0]          rd_frame;
  logic [FIFO_AW-1:0]   wr_ptr, rd_ptr, wr_addr;
  logic [FIFO_AW:0]     level, level_n;

  assign tick       = enable && (counter == rate_div);
  assign empty      = (level == '0);
  assign fifo_full  = (level == DEPTH_LV);
  assign fifo_level = level;
  assign rd_frame   = mem[rd_ptr];

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    starve  = 1'b0;
    if (!enable) begin
      state_n = ST_OFF;
    end else begin
      case (state)
        ST_OFF:   state_n = ST_PRIME;
        ST_PRIME: if (level >= PRIME_LV) state_n = ST_RUN;
        ST_RUN: begin
          if (tick) begin
            if (empty) begin
              starve  = 1'b1;
              state_n = ST_PRIME;
            end else begin
              pop = 1'b1;
            end
          end
        end
        default:  state_n = ST_OFF;
      endcase
    end
  end

  // A push in the flush cycle lands at slot 0 of the freshly emptied FIFO.
  always_comb begin
    flush   = (state != ST_OFF) && !enable;
    push    = wr_en && !fifo_full;
    drop    = wr_en && fifo_full;
    wr_addr = flush ? '0 : wr_ptr;
    level_n = level;
    if (flush) begin
      level_n = push ? (FIFO_AW+1)'(1) : '0;
    end else if (push && !pop) begin
      level_n = level + (FIFO_AW+1)'(1);
    end else if (pop && !push) begin
      level_n = level - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_OFF;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) counter <= '0;
    else if (tick)        counter <= '0;
    else                  counter <= counter + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_addr + FIFO_AW'(1);
      else if (flush) wr_ptr <= '0;
      if (flush)    rd_ptr <= '0;
      else if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
      level <= level_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_sample <= 1'b0;
      left_data   <= '0;
      right_data  <= '0;
    end else begin
      next_sample <= pop || starve;
      if (pop) begin
        left_data  <= rd_frame[31:16];
        right_data <= rd_frame[15:0];
      end else if (starve) begin
        left_data  <= 16'h0000;
        right_data <= 16'h0000;
      end
    end
  end

  // Set events win over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (starve)          underrun <= 1'b1;
      else if (status_clr) underrun <= 1'b0;
      if (drop)            overflow <= 1'b1;
      else if (status_clr) overflow <= 1'b0;
    end
  end

`ifdef AQP_AUDIO_SCHED_IRQ_EN
  localparam logic [FIFO_AW:0] HALF_LV = (FIFO_AW+1)'(1 << (FIFO_AW-1));

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= (state_n != ST_OFF) && (level_n < HALF_LV);
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_aqp_audio_sched.sv
// tb/tb_aqp_audio_sched.sv - table-driven and scoreboard bench for aqp_audio_sched.
module tb_aqp_audio_sched;

  localparam int DEPTH = 16;
`ifdef AQP_AUDIO_SCHED_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] rate_div = 16'd3;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic        status_clr = 1'b0;
  logic        fifo_full;
  logic [4:0]  fifo_level;
  logic        underrun, overflow, irq, next_sample;
  logic [15:0] left_data, right_data;

  aqp_audio_sched #(.FIFO_AW(4), .PRIME_LEVEL(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
    .wr_en(wr_en), .wr_data(wr_data), .status_clr(status_clr),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .underrun(underrun),
    .overflow(overflow), .irq(irq), .next_sample(next_sample),
    .left_data(left_data), .right_data(right_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] data;
    logic        clr;
    logic [4:0]  level;
    logic        full;
    logic        ovf;
  } vec_t;

  vec_t        tbl [20];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] sb [$];
  int          pulse_cyc [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [31:0] f;
    @(posedge clk);
    #1;
    cyc++;
    if (next_sample === 1'b1) begin
      pulse_cyc.push_back(cyc);
      if (sb.size() > 0) begin
        f = sb.pop_front();
        chk("sample_left", 32'(left_data), 32'(f[31:16]));
        chk("sample_right", 32'(right_data), 32'(f[15:0]));
      end else begin
        chk("silence_left", 32'(left_data), 32'h0);
        chk("silence_right", 32'(right_data), 32'h0);
        chk("underrun_on_silence", 32'(underrun), 32'd1);
      end
    end
    chk("fifo_level", 32'(fifo_level), 32'(sb.size()));
  endtask

  task automatic push_drive(input logic [31:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    if (sb.size() < DEPTH) sb.push_back(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_pulse(input int max);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      step();
      if (next_sample === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("pulse_wait", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    enable     = 1'b0;
    wr_en      = 1'b0;
    status_clr = 1'b0;
    sb.delete();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_next_sample"}, 32'(next_sample), 32'd0);
    chk({tag, "_left"}, 32'(left_data), 32'd0);
    chk({tag, "_right"}, 32'(right_data), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_full"}, 32'(fifo_full), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{1'b1, {16'(i + 256), 16'(61440 + i)}, 1'b0, 5'(i + 1), (i == 15), 1'b0};
    end
    tbl[16] = '{1'b1, 32'hBAD0_BAD0, 1'b0, 5'd16, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 5'd16, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 32'hBAD1_BAD1, 1'b1, 5'd16, 1'b1, 1'b1};
    tbl[19] = '{1'b0, 32'h0,         1'b1, 5'd16, 1'b1, 1'b0};

    do_reset();
    chk_reset_state("reset");

    // Fill while OFF, overflow, and clear-versus-set priority
    rate_div = 16'd3;
    for (int i = 0; i < 20; i++) begin
      wr_en      = tbl[i].wr;
      wr_data    = tbl[i].data;
      status_clr = tbl[i].clr;
      if (wr_en && sb.size() < DEPTH) sb.push_back(wr_data);
      step();
      chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].level));
      chk($sformatf("tbl%0d_full", i), 32'(fifo_full), 32'(tbl[i].full));
      chk($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
    end
    wr_en      = 1'b0;
    status_clr = 1'b0;

    // Write dropped while full even though a pop happens in the same cycle
    enable = 1'b1;
    wait_pulse(20);
    push_drive(32'h1234_5678);
    step();
    step();
    wr_en   = 1'b1;
    wr_data = 32'hCAFE_CAFE;
    step();
    wr_en = 1'b0;
    chk("drop_pop_pulse", 32'(next_sample), 32'd1);
    chk("drop_pop_overflow", 32'(overflow), 32'd1);
    chk("drop_pop_level", 32'(fifo_level), 32'd15);
    enable = 1'b0;
    sb.delete();
    step();
    chk("flush_full", 32'(fifo_full), 32'd0);
    chk("flush_irq", 32'(irq), 32'd0);

    // Steady playback at rate_div=3 followed by underrun
    do_reset();
    rate_div = 16'd3;
    for (int i = 1; i <= 8; i++) push_drive({16'(i), 16'(65535 - (i - 1))});
    enable = 1'b1;
    pulse_cyc.delete();
    repeat (60) step();
    chk("play_pulse_count", 32'(pulse_cyc.size()), 32'd9);
    for (int k = 1; k < pulse_cyc.size(); k++)
      chk($sformatf("play_interval%0d", k), 32'(pulse_cyc[k] - pulse_cyc[k-1]), 32'd4);
    chk("play_underrun", 32'(underrun), 32'd1);
    chk("play_left_silent", 32'(left_data), 32'd0);
    chk("play_right_silent", 32'(right_data), 32'd0);
    chk("play_overflow", 32'(overflow), 32'd0);
    chk("prime_irq", 32'(irq), 32'(IRQ_EN));

    // rate_div=0 with a write every cycle keeps the level at 8
    do_reset();
    rate_div = 16'd0;
    for (int i = 0; i < 8; i++) push_drive(32'h0A00_0000 + 32'(i));
    enable = 1'b1;
    step();
    step();
    for (int k = 0; k < 20; k++) begin
      push_drive(32'h0B00_0000 + 32'(k));
      chk("fast_pulse", 32'(next_sample), 32'd1);
      chk("fast_irq", 32'(irq), 32'd0);
    end
    chk("fast_underrun", 32'(underrun), 32'd0);
    chk("fast_overflow", 32'(overflow), 32'd0);
    step();
    chk("lowwater_level", 32'(fifo_level), 32'd7);
    chk("lowwater_irq", 32'(irq), 32'(IRQ_EN));
    enable = 1'b0;
    sb.delete();
    step();
    chk("off_irq", 32'(irq), 32'd0);

    // Reset mid-RUN on the cycle that would have popped
    do_reset();
    rate_div = 16'd3;
    for (int i = 0; i < 8; i++) push_drive(32'h0C00_0000 + 32'(i));
    enable = 1'b1;
    wait_pulse(20);
    wait_pulse(20);
    wait_pulse(20);
    chk("midrun_level", 32'(fifo_level), 32'd5);
    step();
    step();
    step();
    reset = 1'b1;
    sb.delete();
    step();
    reset = 1'b0;
    chk_reset_state("midrun_reset");
    pulse_cyc.delete();
    repeat (20) step();
    chk("post_reset_pulses", 32'(pulse_cyc.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aqp_audio_sched.md
AQP_AUDIO_SCHED -- requirements
Module: aqp_audio_sched

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning FIFO depth = 2^FIFO_AW stereo frames.
REQ-002 SHALL have parameter PRIME_LEVEL, default 8, meaning FIFO level required to leave PRIME state.
REQ-003 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  playback enable.
- rate_div  in  16  sample period minus one, in clk cycles.
- wr_en  in  1  push one frame.
- wr_data  in  32  frame: [31:16] left, [15:0] right, signed.
- status_clr  in  1  clear sticky flags.
- fifo_full  out  1  FIFO holds 2^FIFO_AW frames.
- fifo_level  out  FIFO_AW+1  frames held.
- underrun  out  1  sticky: tick found FIFO empty while in RUN.
- overflow  out  1  sticky: push dropped because FIFO was full.
- irq  out  1  level interrupt: low-water condition.
- next_sample  out  1  one-cycle strobe to the PWM DAC.
- left_data  out  16  signed left sample to the DAC.
- right_data  out  16  signed right sample to the DAC.

Function
REQ-004 Divider counter SHALL count 0..rate_div, then wrap to 0; "tick" = counter == rate_div; counter held at 0 while enable = 0.
REQ-005 rate_div = 0 SHALL give a tick every cycle.
REQ-006 States SHALL be OFF, PRIME, RUN. OFF->PRIME when enable = 1; PRIME->RUN when fifo_level >= PRIME_LEVEL; RUN->PRIME on a tick with FIFO empty; any state->OFF when enable = 0.
REQ-007 On a tick in RUN with FIFO non-empty: pop one frame; left_data/right_data SHALL take it at that edge; next_sample SHALL be 1 for exactly the following cycle.
REQ-008 On a tick in RUN with FIFO empty: outputs SHALL load 16'h0000 (silence), next_sample SHALL pulse, underrun SHALL set, state SHALL go to PRIME.
REQ-009 In PRIME and OFF, ticks SHALL produce no pop and no next_sample pulse; left_data/right_data SHALL hold their last value.
REQ-010 wr_en with FIFO not full SHALL push; wr_en with fifo_full = 1 SHALL drop the frame and set overflow, even when a pop occurs in the same cycle.
REQ-011 Simultaneous push and pop SHALL leave fifo_level unchanged; a pop SHALL never return the frame pushed in the same cycle.
REQ-012 Pointers SHALL wrap modulo 2^FIFO_AW; fifo_level SHALL be a registered value that is exact in every cycle.
REQ-013 status_clr SHALL clear underrun and overflow; a set event in the same cycle SHALL take priority.
REQ-014 Entering OFF SHALL flush the FIFO (level 0); frames written while OFF SHALL still be accepted.

Reset
REQ-015 reset SHALL force state OFF, counter 0, FIFO empty, fifo_level 0, fifo_full 0, underrun 0, overflow 0, irq 0, next_sample 0, left_data 0, right_data 0.
REQ-016 Reset asserted mid-run SHALL discard the in-flight frame with no next_sample pulse in the cycle after reset.

Configuration
REQ-017 With AQP_AUDIO_SCHED_IRQ_EN defined: irq SHALL be registered 1 while state is PRIME or RUN and fifo_level < 2^(FIFO_AW-1), else 0.
REQ-018 Without AQP_AUDIO_SCHED_IRQ_EN: irq SHALL be constant 0 and no low-water logic SHALL be built; the port list SHALL be identical.

Verification
REQ-019 rate_div=3, push 8 frames (0x0001_FFFF, 0x0002_FFFE, ...), enable=1 -> RUN; next_sample exactly every 4 cycles; first pulse carries left=0x0001, right=0xFFFF.
REQ-020 Push 8 frames, enable, stop writing -> after 8 pulses the 9th tick outputs 0/0 with a pulse, underrun=1, state PRIME, no further pulses.
REQ-021 Fill 16 frames, then wr_en with a pop in the same cycle -> frame dropped, overflow=1, fifo_level=15.
REQ-022 rate_div=0, FIFO at 8, wr_en every cycle -> fifo_level stays 8, one pulse per cycle, no flags set.
REQ-023 IRQ_EN defined: level falls from 8 to 7 in RUN -> irq=1 on next cycle; enable=0 -> irq=0, fifo_level=0.
REQ-024 reset pulse mid-RUN with level 5 -> all outputs at REQ-015 values next cycle; no next_sample until re-enable and re-prime.
